// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions used by the trigger, capture and pattern
// generator blocks.
package la_pkg;

  localparam int LA_DATA_W = 8;

  typedef enum logic [1:0] {
    LA_IDLE = 2'd0,
    LA_RUN  = 2'd1,
    LA_TAIL = 2'd2
  } la_state_t;

endpackage

// File: rtl/la_pattern_ram.sv
// Pattern memory: single write port, single registered read port, no reset.
// A write to the address being read returns the new word (write-first).
module la_pattern_ram #(
  parameter int DEPTH_LOG2 = 5,
  parameter int DATA_W     = 8
) (
  input  logic                  CLK,
  input  logic                  WR_EN,
  input  logic [DEPTH_LOG2-1:0] WR_ADDR,
  input  logic [DATA_W-1:0]     WR_DATA,
  input  logic [DEPTH_LOG2-1:0] RD_ADDR,
  output logic [DATA_W-1:0]     RD_DATA
);

  logic [DATA_W-1:0] mem_reg [2**DEPTH_LOG2];

  always_ff @(posedge CLK) begin
    if (WR_EN) begin
      mem_reg[WR_ADDR] <= WR_DATA;
    end
    // Bypass so a START issued on the same edge as a word-0 write sees the new word
    if (WR_EN && (WR_ADDR == RD_ADDR)) begin
      RD_DATA <= WR_DATA;
    end else begin
      RD_DATA <= mem_reg[RD_ADDR];
    end
  end

endmodule

// File: rtl/la_pattern_gen.sv
// LA pattern generator: plays preloaded words onto the LA pins, one per
// CLK_EN strobe, one-shot or looped.
module la_pattern_gen
  import la_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5,
  parameter int DATA_W     = LA_DATA_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLK_EN,
  input  logic                  WR_EN,
  input  logic [DEPTH_LOG2-1:0] WR_ADDR,
  input  logic [DATA_W-1:0]     WR_DATA,
  input  logic [DEPTH_LOG2-1:0] LEN,
  input  logic                  LOOP,
  input  logic                  START,
  input  logic                  STOP,
  input  logic [DATA_W-1:0]     IDLE_DATA,
  output logic [DATA_W-1:0]     DATA_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  SYNC_OUT
);

  la_state_t             state_reg, state_next;
  logic [DEPTH_LOG2-1:0] ptr_reg, ptr_next;
  logic [DEPTH_LOG2-1:0] lenr_reg, lenr_next;
  logic                  loopr_reg, loopr_next;
  logic [DATA_W-1:0]     data_out_reg, data_out_next;
  logic                  done_reg, done_next;
  logic                  sync_reg, sync_next;
  logic [DATA_W-1:0]     rd_data;

  // Reading at ptr_next keeps rd_data equal to mem[ptr_reg] every cycle
  la_pattern_ram #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (DATA_W)
  ) u_ram (
    .CLK    (CLK),
    .WR_EN  (WR_EN && (state_reg == LA_IDLE)),
    .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA),
    .RD_ADDR(ptr_next),
    .RD_DATA(rd_data)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= LA_IDLE;
      ptr_reg      <= '0;
      lenr_reg     <= '0;
      loopr_reg    <= 1'b0;
      data_out_reg <= '0;
      done_reg     <= 1'b0;
      sync_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      lenr_reg     <= lenr_next;
      loopr_reg    <= loopr_next;
      data_out_reg <= data_out_next;
      done_reg     <= done_next;
      sync_reg     <= sync_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    lenr_next     = lenr_reg;
    loopr_next    = loopr_reg;
    data_out_next = data_out_reg;
    done_next     = 1'b0;
    sync_next     = 1'b0;

    case (state_reg)
      LA_IDLE: begin
        data_out_next = IDLE_DATA;
        ptr_next      = '0;
        if (START && !STOP) begin
          lenr_next  = LEN;
          loopr_next = LOOP;
          state_next = LA_RUN;
        end
      end

      LA_RUN: begin
        if (STOP) begin
          data_out_next = IDLE_DATA;
          done_next     = 1'b1;
          ptr_next      = '0;
          state_next    = LA_IDLE;
        end else if (CLK_EN) begin
          data_out_next = rd_data;
          sync_next     = (ptr_reg == '0);
          if (ptr_reg != lenr_reg) begin
            ptr_next = ptr_reg + 1'b1;
          end else if (loopr_reg) begin
            ptr_next = '0;
          end else begin
            // Last word stays on the pins for one more full sample period
            ptr_next   = '0;
            state_next = LA_TAIL;
          end
        end
      end

      LA_TAIL: begin
        if (STOP || CLK_EN) begin
          data_out_next = IDLE_DATA;
          done_next     = 1'b1;
          ptr_next      = '0;
          state_next    = LA_IDLE;
        end
      end

      default: begin
        ptr_next   = '0;
        state_next = LA_IDLE;
      end
    endcase
  end

  assign DATA_OUT = data_out_reg;
  assign BUSY     = (state_reg != LA_IDLE);
  assign DONE     = done_reg;
  assign SYNC_OUT = sync_reg;

endmodule

// File: tb/tb_la_pattern_gen.sv
// Directed bench for la_pattern_gen: vector table for one-shot/loop/stop,
// hand sequences for busy-ignores, LEN=0, LEN=31 wrap and async reset.
module tb_la_pattern_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CLK_EN;
  logic       WR_EN;
  logic [4:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic [4:0] LEN;
  logic       LOOP;
  logic       START;
  logic       STOP;
  logic [7:0] IDLE_DATA;
  logic [7:0] DATA_OUT;
  logic       BUSY;
  logic       DONE;
  logic       SYNC_OUT;

  la_pattern_gen #(.DEPTH_LOG2(5), .DATA_W(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CLK_EN   (CLK_EN),
    .WR_EN    (WR_EN),
    .WR_ADDR  (WR_ADDR),
    .WR_DATA  (WR_DATA),
    .LEN      (LEN),
    .LOOP     (LOOP),
    .START    (START),
    .STOP     (STOP),
    .IDLE_DATA(IDLE_DATA),
    .DATA_OUT (DATA_OUT),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .SYNC_OUT (SYNC_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       en;
    logic       start;
    logic       stop;
    logic       loop;
    logic [4:0] len;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       sync;
  } vec_t;

  vec_t       vt[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] pat[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  function automatic void addv(input logic en, input logic start, input logic stop,
                               input logic loop, input logic [4:0] len, input logic [7:0] data,
                               input logic busy, input logic done, input logic sync);
    vec_t v;
    v.en = en; v.start = start; v.stop = stop; v.loop = loop; v.len = len;
    v.data = data; v.busy = busy; v.done = done; v.sync = sync;
    vt.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic obs(input string tag, input logic [7:0] d, input logic b,
                     input logic dn, input logic s);
    chk({tag, ".data"}, 32'(DATA_OUT), 32'(d));
    chk({tag, ".busy"}, 32'(BUSY), 32'(b));
    chk({tag, ".done"}, 32'(DONE), 32'(dn));
    chk({tag, ".sync"}, 32'(SYNC_OUT), 32'(s));
    $display("%s: data=%02h busy=%0b done=%0b sync=%0b", tag, DATA_OUT, BUSY, DONE, SYNC_OUT);
  endtask

  task automatic clk1();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input logic en, input logic start, input logic stop);
    CLK_EN = en; START = start; STOP = stop;
    clk1();
    CLK_EN = 1'b0; START = 1'b0; STOP = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
    clk1();
    WR_EN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b0; CLK_EN = 1'b0; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    LEN = '0; LOOP = 1'b0; START = 1'b0; STOP = 1'b0; IDLE_DATA = 8'hA5;
    #1 RST = 1'b1;
    #1 obs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 4; i++) wr(5'(i), pat[i]);

    // STOP alone, then START+STOP, in IDLE: nothing happens
    addv(0, 0, 1, 0, 3, 8'hA5, 0, 0, 0);
    addv(0, 1, 1, 0, 3, 8'hA5, 0, 0, 0);
    // One-shot, strobe every 4th cycle
    addv(0, 1, 0, 0, 3, 8'hA5, 1, 0, 0);
    for (int w = 0; w < 4; w++) begin
      for (int g = 0; g < 3; g++) addv(0, 0, 0, 0, 3, (w == 0) ? 8'hA5 : pat[w-1], 1, 0, 0);
      addv(1, 0, 0, 0, 3, pat[w], 1, 0, w == 0);
    end
    for (int g = 0; g < 3; g++) addv(0, 0, 0, 0, 3, 8'h44, 1, 0, 0);
    addv(1, 0, 0, 0, 3, 8'hA5, 0, 1, 0);
    addv(0, 0, 0, 0, 3, 8'hA5, 0, 0, 0);
    // Looped, CLK_EN continuous; strobe coincident with START is not a step
    addv(1, 1, 0, 1, 3, 8'hA5, 1, 0, 0);
    for (int i = 0; i < 10; i++) addv(1, 0, 0, 1, 3, pat[i%4], 1, 0, (i % 4) == 0);
    // STOP with CLK_EN at ptr = 2
    addv(1, 0, 1, 1, 3, 8'hA5, 0, 1, 0);
    addv(0, 0, 0, 1, 3, 8'hA5, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      LEN = vt[i].len; LOOP = vt[i].loop;
      step(vt[i].en, vt[i].start, vt[i].stop);
      obs($sformatf("vec%0d", i), vt[i].data, vt[i].busy, vt[i].done, vt[i].sync);
    end

    // Busy: WR_EN, second START and LEN/LOOP changes are all ignored
    LEN = 3; LOOP = 1'b1;
    step(0, 1, 0);
    obs("busy_start", 8'hA5, 1, 0, 0);
    LEN = 0; LOOP = 1'b0;
    WR_EN = 1'b1; WR_ADDR = 5'd1; WR_DATA = 8'hFF;
    step(1, 1, 0);
    WR_EN = 1'b0;
    obs("busy_w0", 8'h11, 1, 0, 1);
    for (int i = 1; i < 9; i++) begin
      step(1, 0, 0);
      obs($sformatf("busy_w%0d", i), pat[i%4], 1, 0, (i % 4) == 0);
    end
    step(0, 0, 1);
    obs("busy_stop", 8'hA5, 0, 1, 0);

    // LEN = 0 looped, then one-shot
    wr(5'd0, 8'h5A);
    LEN = 0; LOOP = 1'b1;
    step(0, 1, 0);
    obs("len0_start", 8'hA5, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      obs($sformatf("len0_loop%0d", i), 8'h5A, 1, 0, 1);
    end
    step(0, 0, 0);
    obs("len0_hold", 8'h5A, 1, 0, 0);
    step(0, 0, 1);
    obs("len0_stop", 8'hA5, 0, 1, 0);
    LOOP = 1'b0;
    step(0, 1, 0);
    step(1, 0, 0);
    obs("len0_oneshot", 8'h5A, 1, 0, 1);
    step(1, 0, 0);
    obs("len0_tail", 8'hA5, 0, 1, 0);

    // LEN = 31 full-depth wrap
    for (int i = 0; i < 32; i++) wr(5'(i), 8'(8'h80 + i));
    LEN = 5'd31; LOOP = 1'b1;
    step(0, 1, 0);
    for (int i = 0; i < 34; i++) begin
      step(1, 0, 0);
      obs($sformatf("len31_%0d", i), 8'(8'h80 + (i % 32)), 1, 0, (i % 32) == 0);
    end
    step(0, 0, 1);
    obs("len31_stop", 8'hA5, 0, 1, 0);

    // Asynchronous reset mid-playback
    step(0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    obs("pre_rst", 8'h84, 1, 0, 0);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 obs("rst_async", 8'h00, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b0;
    step(0, 1, 0);
    obs("post_rst_start", 8'hA5, 1, 0, 0);
    step(1, 0, 0);
    obs("post_rst_w0", 8'h80, 1, 0, 1);
    step(1, 0, 0);
    obs("post_rst_w1", 8'h81, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/la_pattern_gen.md
# la_pattern_gen

Logic-analyzer pattern generator: the transmit-side counterpart to the LA trigger/capture path. The MCU preloads up to 2^DEPTH_LOG2 8-bit words. After START, one word is driven onto the LA pins per CLK_EN sample strobe, either one-shot or looped. It lets the board stimulate a DUT, or its own LA inputs, with the same sample timebase the trigger logic uses.

## Interface
- DEPTH_LOG2, 5, pattern memory address width (32 words)
- DATA_W, 8, pattern word / LA channel width
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- CLK_EN  in  1  sample strobe; one pattern step per cycle it is high
- WR_EN  in  1  write WR_DATA to pattern memory at WR_ADDR
- WR_ADDR  in  DEPTH_LOG2  pattern memory write address
- WR_DATA  in  DATA_W  pattern word
- LEN  in  DEPTH_LOG2  index of last word (sequence length − 1)
- LOOP  in  1  1 = wrap to word 0 after LEN, 0 = one-shot
- START  in  1  single-cycle pulse, begin playback
- STOP  in  1  single-cycle pulse, abort playback
- IDLE_DATA  in  DATA_W  level driven on pins when not playing
- DATA_OUT  out  DATA_W  registered LA output pins
- BUSY  out  1  high while state ≠ IDLE
- DONE  out  1  one-cycle pulse when playback ends (one-shot completion or STOP)
- SYNC_OUT  out  1  one-cycle pulse on every edge where word 0 is driven (scope/trigger marker)

## Operation
- States: IDLE, RUN, TAIL.
- IDLE: DATA_OUT <= IDLE_DATA every cycle; ptr = 0. WR_EN writes memory. START (without STOP) latches LEN and LOOP into lenr and loopr, sets ptr = 0, and moves to RUN.
- RUN, on CLK_EN: DATA_OUT <= mem[ptr]; SYNC_OUT = 1 if ptr == 0.
  - If ptr ≠ lenr: ptr <= ptr + 1.
  - If ptr == lenr and loopr: ptr <= 0.
  - If ptr == lenr and !loopr: go to TAIL.
- RUN/TAIL without CLK_EN: all registers hold; DATA_OUT is stable for the whole sample period.
- TAIL, on CLK_EN: DATA_OUT <= IDLE_DATA, DONE = 1, go to IDLE. The last word therefore lasts exactly one full sample period.
- STOP in RUN or TAIL takes priority over CLK_EN: DATA_OUT <= IDLE_DATA, DONE = 1, go to IDLE.
- STOP in IDLE: no effect, no DONE. START and STOP together in IDLE: stay IDLE, no DONE.
- START while BUSY: ignored. WR_EN while BUSY: ignored, so memory is frozen during playback.
- LEN/LOOP changes while BUSY have no effect; the latched copies are used.
- LEN = 0: single word. Looped, that word repeats and SYNC_OUT pulses on every CLK_EN.
- ptr is DEPTH_LOG2 bits. lenr = 2^DEPTH_LOG2 − 1 wraps naturally to 0.
- Memory: synchronous single-write/single-read. Read address = next-state ptr, so the registered read data always equals mem[ptr]. Back-to-back CLK_EN works with no bubble.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset (async assert): DATA_OUT = 0, BUSY = 0, DONE = 0, SYNC_OUT = 0, state IDLE, ptr = 0, lenr = 0, loopr = 0. Reset release is synchronous to CLK.
- RST asserted mid-playback: immediate return to reset values, no DONE.
- START at edge t: BUSY high after t. The earliest CLK_EN that can drive word 0 is sampled at edge t+1. A CLK_EN coincident with START is not a step.
- DATA_OUT changes only on the edge that samples CLK_EN (or STOP), giving 1-cycle latency from strobe to pins.
- DONE and IDLE_DATA on the pins occur on the same edge. BUSY falls on that edge.
- SYNC_OUT is coincident with the DATA_OUT update to word 0.
- CLK_EN may be high continuously, which gives one word per clock.

## Structure
- Shared package la_pkg: state encoding (IDLE/RUN/TAIL) and LA_DATA_W = 8. The trigger, capture and generator blocks share it.
- One sub-module: la_pattern_ram (parameterised DEPTH_LOG2 × DATA_W, sync write, registered read, no reset), mapping cleanly to EPM570/UFM-free LEs or block RAM.
- Controller FSM, pointer and output register live in la_pattern_gen.

## Test plan
- Write mem[0..3] = 0x11, 0x22, 0x33, 0x44; LEN = 3, LOOP = 0, IDLE_DATA = 0xA5; START, then CLK_EN every 4th cycle -> DATA_OUT 0x11, 0x22, 0x33, 0x44, 0xA5 on successive strobe edges; DONE on the 0xA5 edge; SYNC_OUT on the 0x11 edge only.
- Same data, LOOP = 1, CLK_EN held high for 10 cycles -> 0x11, 0x22, 0x33, 0x44, 0x11, ..., with no bubble; SYNC_OUT every 4th cycle; BUSY stays high; no DONE.
- LOOP = 1 playing, STOP together with CLK_EN at ptr = 2 -> DATA_OUT = IDLE_DATA next edge, DONE pulse, BUSY low, ptr = 0.
- While BUSY, WR_EN to addr 1 with 0xFF and a second START -> both ignored; next pass still outputs 0x22 at index 1.
- LEN = 0, LOOP = 1, mem[0] = 0x5A -> 0x5A on every strobe, SYNC_OUT every strobe; LEN = 31 (wrap) plays all 32 words and returns to word 0.
- Assert RST mid-RUN -> DATA_OUT = 0, BUSY = 0, DONE = 0 immediately; memory contents preserved; a new START replays from word 0.
